// File: rtl/systolic_ctrl.sv
// systolic_ctrl: clears the array, latches W, streams M X rows in and captures M Y rows out per job
module systolic_ctrl #(
  parameter int M = 5,
  parameter int N = 3,
  parameter int K = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_LAT = 6,
  localparam int AW = (M > 1) ? $clog2(M) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [DATA_WIDTH*N*K-1:0]    w_in,
  output logic                         busy,
  output logic                         done,
  output logic                         x_rd_en,
  output logic [AW-1:0]                x_rd_addr,
  input  logic [DATA_WIDTH*N-1:0]      x_rd_data,
  output logic                         arr_rst,
  output logic [DATA_WIDTH*N-1:0]      arr_X,
  output logic [DATA_WIDTH*N*K-1:0]    arr_W,
  input  logic [DATA_WIDTH*K-1:0]      arr_Y,
  output logic                         y_wr_en,
  output logic [AW-1:0]                y_wr_addr,
  output logic [DATA_WIDTH*K-1:0]      y_wr_data
);
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
  localparam logic [AW-1:0] LAST = AW'(M - 1);
  state_t state;
  logic [AW-1:0] rd_cnt, wr_cnt;
  logic [DATA_WIDTH*N*K-1:0] w_reg;
  // sr[0] is the read-valid flag; sr[ARRAY_LAT] marks the matching Y row leaving the array
  logic [ARRAY_LAT:0] sr;
  logic wr;
  assign wr = sr[ARRAY_LAT];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rd_cnt <= '0;
      wr_cnt <= '0;
      w_reg <= '0;
      sr <= '0;
    end else begin
      sr <= {sr[ARRAY_LAT-1:0], state == FEED};
      if (wr && wr_cnt != LAST) wr_cnt <= wr_cnt + 1'b1;
      case (state)
        IDLE: if (start) begin
          w_reg <= w_in;
          rd_cnt <= '0;
          wr_cnt <= '0;
          state <= CLEAR;
        end
        CLEAR: state <= FEED;
        FEED: if (rd_cnt == LAST) state <= DRAIN; else rd_cnt <= rd_cnt + 1'b1;
        DRAIN: if (wr && wr_cnt == LAST) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
  // outputs are forced to their reset values during the cycle rst is asserted
  assign busy      = !rst && state != IDLE;
  assign done      = !rst && state == DONE;
  assign x_rd_en   = !rst && state == FEED;
  assign x_rd_addr = rst ? '0 : rd_cnt;
  assign arr_rst   = rst || state == CLEAR;
  assign arr_X     = (!rst && sr[0]) ? x_rd_data : '0;
  assign arr_W     = rst ? '0 : w_reg;
  assign y_wr_en   = !rst && wr;
  assign y_wr_addr = rst ? '0 : wr_cnt;
  assign y_wr_data = arr_Y;
endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencing controller for `systolic_array`. On a start pulse it clears the array, latches the weight matrix, and streams the M rows of X from a row-addressed source buffer into the array, one row per cycle. It then captures the M result rows of Y into a destination buffer and signals completion. It sits between the X/Y buffers and the array, replacing the free-running hookup in the top level.

## Interface
- `M`, 5: rows of X, and rows of Y produced per job
- `N`, 3: elements per X row (array input width)
- `K`, 4: elements per Y row (array output width)
- `DATA_WIDTH`, 8: bits per element
- `ARRAY_LAT`, 6: cycles from an X row on `arr_X` to its Y row valid on `arr_Y`; must be ≥1
- `AW`, derived: max(1, $clog2(M)), address width

Ports:
- `clk` in 1: single clock, all logic on posedge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: job request, sampled only in IDLE
- `w_in` in DATA_WIDTH*N*K: weight matrix, sampled on the accepted start
- `busy` out 1: job in progress
- `done` out 1: one-cycle completion pulse
- `x_rd_en` out 1: X buffer read strobe
- `x_rd_addr` out AW: X row address
- `x_rd_data` in DATA_WIDTH*N: X row, valid the cycle after `x_rd_en`
- `arr_rst` out 1: array reset
- `arr_X` out DATA_WIDTH*N: array X input
- `arr_W` out DATA_WIDTH*N*K: array W input (latched copy)
- `arr_Y` in DATA_WIDTH*K: array Y output
- `y_wr_en` out 1: Y buffer write strobe
- `y_wr_addr` out AW: Y row address
- `y_wr_data` out DATA_WIDTH*K: Y row

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE, with `start`=1: latch `w_in` into the W register, go to CLEAR. If `start`=0, stay in IDLE.
- CLEAR: one cycle. Drives `arr_rst`=1, then goes to FEED.
- FEED: M cycles. `x_rd_en`=1 and `x_rd_addr` counts 0..M-1. Goes to DRAIN after address M-1 is issued.
- Read-valid flag: `x_rd_en` delayed one cycle.
  - When the flag is high, `arr_X` = `x_rd_data`.
  - When the flag is low, `arr_X` = 0.
- Capture pipeline: the read-valid flag feeds a shift register ARRAY_LAT deep.
  - When the shift register output is high, `y_wr_en`=1, `y_wr_data`=`arr_Y` (combinational pass-through), and `y_wr_addr` = write counter.
  - The write counter increments on each write, 0..M-1.
- DRAIN: waits until the M-th write occurs, then goes to DONE.
- DONE: one cycle with `done`=1, then goes to IDLE.
- `busy`=1 in every state except IDLE.
- `arr_rst` = `rst` OR (state==CLEAR).
- `arr_W` = W register at all times. The W register holds its value across jobs until the next accepted start.
- `start` is ignored in every state other than IDLE, including DONE.
- Counters never wrap: the read counter stops at M-1, and the write counter is cleared on entry to CLEAR.

## Timing
Let start be sampled high in IDLE at cycle t.
- t+1: CLEAR, `arr_rst`=1, `busy`=1.
- t+2 .. t+M+1: `x_rd_en`=1, with `x_rd_addr`=i at cycle t+2+i.
- t+3+i: row i on `arr_X`.
- t+3+i+ARRAY_LAT: `y_wr_en`=1, `y_wr_addr`=i.
- t+M+3+ARRAY_LAT: `done`=1, still `busy`=1.
- Next cycle: IDLE, `busy`=0. A start in this cycle is accepted, so back-to-back jobs have a one-cycle idle gap.

Reset behaviour:
- Values while `rst`=1 and after its release:
  - state IDLE
  - `busy`, `done`, `x_rd_en`, `y_wr_en` = 0
  - `x_rd_addr`, `y_wr_addr` = 0
  - `arr_X` = 0
  - W register = 0, so `arr_W` = 0
  - capture shift register cleared
  - `arr_rst`=1 while `rst` is high
- Reset mid-job aborts with no further reads or writes. The next start runs a full fresh job.
- `y_wr_data` is don't-care when `y_wr_en`=0.

## Test plan
Defaults: M=5, N=3, K=4, ARRAY_LAT=6. The array is stubbed with a 6-cycle delay model, Y[k] = sum over n of X[n]*W[n][k].
- Basic job: start at cycle 0 → `arr_rst` high at cycle 1 only; reads of addr 0..4 at cycles 2..6; writes of addr 0..4 at cycles 9..13 with correct Y rows; `done` at cycle 14; `busy` high cycles 1..14.
- Start while busy: pulse start at cycles 0, 5 and 14 → exactly one job runs; a start at cycle 15 starts a second job with `arr_rst` at cycle 16 and `done` at cycle 29.
- Weight latch: change `w_in` at cycle 3 of a job → `arr_W` and all results use the value sampled at cycle 0.
- Reset mid-job: `rst` high at cycle 8 → no `y_wr_en` from cycle 8 on; all outputs at reset values; a new start produces the full 5 writes and `done`.
- Bubble check: X buffer returns 0xFF on unread cycles → `arr_X`=0 at cycles 0..2 and 8..14.
- Edge configuration M=1, ARRAY_LAT=1 (AW=1), start at cycle 0 → one read at cycle 2, one write of addr 0 at cycle 4, `done` at cycle 5.
